// File: rtl/centroid_unpacking_reader_if.sv
// Bundle of the centroid reader's control, memory-read and centroid-stream signals.
// master = the reader itself; slave = its environment (controller, memory, datapath).
interface centroid_unpacking_reader_if #(
    parameter int addrWidth        = 8,
    parameter int dataWidth        = 91,
    parameter int idx_width        = 3,
    parameter int accum_cord_width = 22
);
    logic                        start;
    logic [addrWidth-1:0]        base_addr;
    logic                        mem_rd_en;
    logic [addrWidth-1:0]        mem_addr;
    logic [dataWidth-1:0]        mem_rd_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [idx_width-1:0]        centroid_idx;
    logic [accum_cord_width-1:0] cord_1;
    logic [accum_cord_width-1:0] cord_2;
    logic [accum_cord_width-1:0] cord_3;
    logic [accum_cord_width-1:0] cord_4;
    logic [accum_cord_width-1:0] cord_5;
    logic [accum_cord_width-1:0] cord_6;
    logic [accum_cord_width-1:0] cord_7;
    logic                        busy;
    logic                        done;

    modport master (
        input  start, base_addr, mem_rd_data, out_ready,
        output mem_rd_en, mem_addr, out_valid, centroid_idx,
               cord_1, cord_2, cord_3, cord_4, cord_5, cord_6, cord_7,
               busy, done
    );

    modport slave (
        output start, base_addr, mem_rd_data, out_ready,
        input  mem_rd_en, mem_addr, out_valid, centroid_idx,
               cord_1, cord_2, cord_3, cord_4, cord_5, cord_6, cord_7,
               busy, done
    );
endinterface

// File: rtl/centroid_unpacking_reader.sv
// Reads packed centroid words from memory, splits each into seven coordinates,
// extends them and presents one centroid at a time over a valid/ready handshake.
module centroid_unpacking_reader #(
    parameter bit tc_mode          = 1'b0,
    parameter int addrWidth        = 8,
    parameter int dataWidth        = 91,
    parameter int centroid_num     = 8,
    parameter int accum_cord_width = 22,
    parameter int cordinate_width  = 13,
    localparam int idx_width       = (centroid_num > 1) ? $clog2(centroid_num) : 1
) (
    input  logic clk,
    input  logic rst,
    centroid_unpacking_reader_if.master bus
);

    localparam int num_cords = 7;
    localparam int ext_width = accum_cord_width - cordinate_width;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [addrWidth-1:0]        base_q;
    logic [idx_width-1:0]        idx_q;
    logic                        busy_q;
    logic                        out_valid_q;
    logic [idx_width-1:0]        centroid_idx_q;
    logic [accum_cord_width-1:0] cord_q [num_cords];
    logic                        handshake;
    logic                        last_centroid;

    function automatic logic [accum_cord_width-1:0] extend(
        input logic [cordinate_width-1:0] field
    );
        if (tc_mode)
            return {{ext_width{field[cordinate_width-1]}}, field};
        else
            return {{ext_width{1'b0}}, field};
    endfunction

    assign handshake     = out_valid_q & bus.out_ready;
    assign last_centroid = (idx_q == idx_width'(centroid_num - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        bus.mem_rd_en = 1'b0;
        bus.mem_addr  = '0;
        bus.done      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_READ;
            end
            S_READ: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = base_q + addrWidth'(idx_q);
                state_d       = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (handshake) state_d = last_centroid ? S_DONE : S_READ;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the coordinate registers are flops, not a memory, so they are
    // reset with everything else and read as 0 straight after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q         <= '0;
            idx_q          <= '0;
            busy_q         <= 1'b0;
            out_valid_q    <= 1'b0;
            centroid_idx_q <= '0;
            for (int k = 0; k < num_cords; k++) cord_q[k] <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        base_q <= bus.base_addr;
                        idx_q  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    // Read data arrives exactly one cycle after the READ strobe.
                    for (int k = 0; k < num_cords; k++)
                        cord_q[k] <= extend(bus.mem_rd_data[k*cordinate_width +: cordinate_width]);
                    centroid_idx_q <= idx_q;
                    out_valid_q    <= 1'b1;
                end
                S_PRESENT: begin
                    if (handshake) begin
                        out_valid_q <= 1'b0;
                        if (!last_centroid) idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.centroid_idx = centroid_idx_q;
    assign bus.busy         = busy_q;
    assign bus.cord_1       = cord_q[0];
    assign bus.cord_2       = cord_q[1];
    assign bus.cord_3       = cord_q[2];
    assign bus.cord_4       = cord_q[3];
    assign bus.cord_5       = cord_q[4];
    assign bus.cord_6       = cord_q[5];
    assign bus.cord_7       = cord_q[6];

endmodule
